// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate; used both for operand magnitude and result sign fixup.
module mdu_signfix #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// One step per cycle on magnitudes; done WIDTH+1 edges after the start edge.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH-1:0]   opnd;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               dz_r;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic               div_by_zero;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign a_neg       = op_is_signed(op) & a[WIDTH-1];
   assign b_neg       = op_is_signed(op) & b[WIDTH-1];
   assign div_by_zero = op_is_div(op) && (b == '0);

   mdu_signfix #(.WIDTH(WIDTH)) u_abs_a (.neg(a_neg), .din(a), .dout(a_abs));
   mdu_signfix #(.WIDTH(WIDTH)) u_abs_b (.neg(b_neg), .din(b), .dout(b_abs));

   mdu_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
      .neg  (neg_q),
      .din  ({acc_hi, acc_lo}),
      .dout (prod_fix)
   );
   mdu_signfix #(.WIDTH(WIDTH)) u_fix_quo (.neg(neg_q), .din(acc_lo), .dout(quo_fix));
   mdu_signfix #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_r), .din(acc_hi), .dout(rem_fix));

   // Multiply: acc_lo holds the remaining multiplier bits, product shifts in from the top.
   always_comb begin
      mul_sum = {1'b0, acc_hi};
      if (acc_lo[0]) begin
         mul_sum = {1'b0, acc_hi} + {1'b0, opnd};
      end
   end

   // Divide: partial remainder stays below the divisor, so the top diff bit is an exact borrow.
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd};
   assign div_ge    = ~div_diff[WIDTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz_r   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         dz_r <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  if (div_by_zero) begin
                     state <= ST_DONE;
                     dz_r  <= 1'b1;
                  end else begin
                     state  <= ST_CALC;
                     cnt    <= '0;
                     is_div <= op_is_div(op);
                     neg_q  <= a_neg ^ b_neg;
                     neg_r  <= a_neg;
                     acc_hi <= '0;
                     acc_lo <= a_abs;
                     opnd   <= b_abs;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_CALC: begin
               if (is_div) begin
                  acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
               end else begin
                  acc_hi <= mul_sum[WIDTH:1];
                  acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               cnt   <= '0;
               state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state == ST_CALC) || (state == ST_FIX);
   assign done = (state == ST_DONE);
   assign dz   = dz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int LAT32 = 33;
   localparam int LAT8  = 9;

   logic        clk;
   logic        reset;

   logic        start, hi_we, lo_we, busy, done, dz;
   logic [1:0]  op;
   logic [31:0] a, b, wdata, hi, lo;

   logic        start8, hi_we8, lo_we8, busy8, done8, dz8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, wdata8, hi8, lo8;

   int checks;
   int errors;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
      .busy(busy8), .done(done8), .dz(dz8), .hi(hi8), .lo(lo8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic do_op32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic do_op8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         output int lat);
      @(negedge clk);
      op8 = o; a8 = x; b8 = y; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!done8) lat = -1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
      checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (dz !== 1'b0)   begin errors++; $display("FAIL reset_dz: got %b expected 0", dz); end
      reset = 1'b1;
   endtask

   task automatic test_mult();
      int lat;
      do_op32(OP_MULT, 32'hFFFFFFFE, 32'd3, lat);
      checks++; if (lat !== LAT32) begin errors++; $display("FAIL mult_latency: got %0d expected %0d", lat, LAT32); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done: got %b expected 0", busy); end
      do_op32(OP_MULTU, 32'hFFFFFFFE, 32'd3, lat);
      checks++; if (lat !== LAT32) begin errors++; $display("FAIL multu_latency: got %0d expected %0d", lat, LAT32); end
      checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL multu_hi: got %h expected 00000002", hi); end
      checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo: got %h expected fffffffa", lo); end
   endtask

   task automatic test_div();
      int lat;
      do_op32(OP_DIV, 32'hFFFFFFF9, 32'd2, lat);
      checks++; if (lat !== LAT32) begin errors++; $display("FAIL div_latency: got %0d expected %0d", lat, LAT32); end
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
      do_op32(OP_DIVU, 32'd7, 32'd2, lat);
      checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected 3", lo); end
      checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected 1", hi); end
      do_op32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
      checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 0", hi); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_ovf_dz: got %b expected 0", dz); end
      do_op32(OP_DIV, 32'd100, 32'hFFFFFFF9, lat);
      checks++; if (lo !== 32'hFFFFFFF2) begin errors++; $display("FAIL div_negb_lo: got %h expected fffffff2", lo); end
      checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div_negb_hi: got %h expected 2", hi); end
   endtask

   task automatic test_div_zero();
      int lat;
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h00001234;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h00005678;
      @(negedge clk);
      lo_we = 1'b0;
      checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL mthi: got %h expected 00001234", hi); end
      checks++; if (lo !== 32'h00005678) begin errors++; $display("FAIL mtlo: got %h expected 00005678", lo); end
      do_op32(OP_DIVU, 32'd5, 32'd0, lat);
      checks++; if (lat !== 0) begin errors++; $display("FAIL dz_latency: got %0d expected 0", lat); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", dz); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy: got %b expected 0", busy); end
      checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL dz_hi: got %h expected 00001234", hi); end
      checks++; if (lo !== 32'h00005678) begin errors++; $display("FAIL dz_lo: got %h expected 00005678", lo); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dz_done_clear: got %b expected 0", done); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b expected 0", dz); end
   endtask

   task automatic test_ignore_busy();
      int lat;
      @(negedge clk);
      op = OP_MULT; a = 32'd7; b = 32'hFFFFFFFD; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         lat++;
         start = i[0]; op = OP_DIVU; a = 32'd1; b = 32'd1;
         hi_we = i[0]; lo_we = i[0]; wdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      lat++;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b expected 1", busy); end
      checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL ign_hi_we: got %h expected 00001234", hi); end
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (lat !== LAT32) begin errors++; $display("FAIL ign_latency: got %0d expected %0d", lat, LAT32); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL ign_hi: got %h expected ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL ign_lo: got %h expected ffffffeb", lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_done: got %b expected 0", busy); end
   endtask

   task automatic test_reset_abort();
      int lat;
      @(negedge clk);
      op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
      reset = 1'b0;
      #1;
      checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL abort_hi: got %h expected 0", hi); end
      checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL abort_lo: got %h expected 0", lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      @(negedge clk);
      reset = 1'b1;
      do_op32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
      checks++; if (lat !== LAT32) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, LAT32); end
      checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL post_reset_hi: got %h expected fffffffe", hi); end
      checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL post_reset_lo: got %h expected 00000001", lo); end
   endtask

   task automatic test_write_with_start();
      int lat;
      @(negedge clk);
      op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000AAAA;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      checks++; if (hi !== 32'h0000AAAA) begin errors++; $display("FAIL ws_hi_write: got %h expected 0000aaaa", hi); end
      checks++; if (lo !== 32'h0000AAAA) begin errors++; $display("FAIL ws_lo_write: got %h expected 0000aaaa", lo); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ws_busy: got %b expected 1", busy); end
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (lat !== LAT32) begin errors++; $display("FAIL ws_latency: got %0d expected %0d", lat, LAT32); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ws_hi: got %h expected 0", hi); end
      checks++; if (lo !== 32'd12) begin errors++; $display("FAIL ws_lo: got %h expected c", lo); end
   endtask

   task automatic test_width8();
      int lat;
      do_op8(OP_MULT, 8'h80, 8'h80, lat);
      checks++; if (lat !== LAT8) begin errors++; $display("FAIL w8_latency: got %0d expected %0d", lat, LAT8); end
      checks++; if ({hi8, lo8} !== 16'h4000) begin errors++; $display("FAIL w8_mult: got %h expected 4000", {hi8, lo8}); end
      // back-to-back: new start presented while done8 is high
      op8 = OP_MULTU; a8 = 8'hFF; b8 = 8'h02; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL w8_b2b_busy: got %b expected 1", busy8); end
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL w8_b2b_done: got %b expected 0", done8); end
      lat = 0;
      while (!done8 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (lat !== LAT8) begin errors++; $display("FAIL w8_b2b_latency: got %0d expected %0d", lat, LAT8); end
      checks++; if ({hi8, lo8} !== 16'h01FE) begin errors++; $display("FAIL w8_b2b_result: got %h expected 01fe", {hi8, lo8}); end
      do_op8(OP_DIV, 8'h80, 8'hFF, lat);
      checks++; if ({hi8, lo8} !== 16'h0080) begin errors++; $display("FAIL w8_div_ovf: got %h expected 0080", {hi8, lo8}); end
      do_op8(OP_DIV, 8'hF9, 8'h02, lat);
      checks++; if ({hi8, lo8} !== 16'hFFFD) begin errors++; $display("FAIL w8_div_neg: got %h expected fffd", {hi8, lo8}); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      start = 1'b0; op = 2'b00; a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; hi_we8 = 1'b0; lo_we8 = 1'b0; wdata8 = '0;
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_ignore_busy();
      test_reset_abort();
      test_write_with_start();
      test_width8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
